// File: rtl/xc20xx_clb_cfg.sv
// -----------------------------------------------------------------------------
// xc20xx_clb_cfg
//
// Run-time configurable CLB tile primitive. Two LUT_K-input LUTs (F, G), an
// optional F/G wide-function mux, one clock-enabled storage flop (Q) and X/Y
// output selects. All of these are controlled by a configuration word that is
// shifted in serially, MSB first.
//
// A shadow register collects the incoming word while the active word keeps
// driving the datapath. The new word is copied into the active register as
// one atomic step, so the logic outputs never see a partially loaded word.
//
// Config word, MSB..LSB:
//   {F_INIT[2**LUT_K-1:0], G_INIT[2**LUT_K-1:0], MUX_FG, DSEL, CESEL,
//    XSEL[1:0], YSEL[1:0]}
//
// Ports
//   K          clock, rising edge
//   RST_N      asynchronous active-low reset
//   IN         logic inputs; IN[LUT_K-1:0] = LUT address,
//              IN[LUT_K] = F/G mux select and flop enable
//   X, Y       selected outputs (0=F, 1=G, 2=Q, 3=const 0); 0 until configured
//   CFG_START  pulse: begin or restart loading a word
//   CFG_VALID  CFG_DIN carries a valid bit
//   CFG_READY  a bit is accepted this cycle (high only while shifting)
//   CFG_DIN    serial configuration bit
//   CFG_DONE   one-cycle pulse when the new word becomes active
//   CFG_OK     level: at least one word committed since reset
// -----------------------------------------------------------------------------
module xc20xx_clb_cfg #(
    parameter int LUT_K = 3
) (
    input  logic           K,
    input  logic           RST_N,
    input  logic [LUT_K:0] IN,
    output logic           X,
    output logic           Y,
    input  logic           CFG_START,
    input  logic           CFG_VALID,
    output logic           CFG_READY,
    input  logic           CFG_DIN,
    output logic           CFG_DONE,
    output logic           CFG_OK
);

    localparam int LUT_N = 2 ** LUT_K;
    localparam int CFG_W = 2 * LUT_N + 7;
    localparam int CNT_W = $clog2(CFG_W);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic             commit_q, commit_d;   // COMMIT state seen last cycle
    logic             ok_q,     ok_d;
    logic             done_q,   done_d;
    logic             q_q,      q_d;

    // Fields of the active configuration word.
    logic [LUT_N-1:0] f_init;
    logic [LUT_N-1:0] g_init;
    logic             mux_fg;
    logic             dsel;
    logic             cesel;
    logic [1:0]       xsel;
    logic [1:0]       ysel;

    assign f_init = active_q[CFG_W-1 -: LUT_N];
    assign g_init = active_q[CFG_W-1-LUT_N -: LUT_N];
    assign mux_fg = active_q[6];
    assign dsel   = active_q[5];
    assign cesel  = active_q[4];
    assign xsel   = active_q[3:2];
    assign ysel   = active_q[1:0];

    // Datapath, purely combinational from the active word.
    logic [LUT_K-1:0] lut_idx;
    logic             f_lut;
    logic             g_val;
    logic             f_val;
    logic             ce;

    assign lut_idx = IN[LUT_K-1:0];
    assign f_lut   = f_init[lut_idx];
    assign g_val   = g_init[lut_idx];
    assign f_val   = (mux_fg && IN[LUT_K]) ? g_val : f_lut;
    assign ce      = cesel ? IN[LUT_K] : 1'b1;

    function automatic logic out_sel(input logic [1:0] sel, input logic f,
                                     input logic g, input logic q);
        logic r;
        case (sel)
            2'd0:    r = f;
            2'd1:    r = g;
            2'd2:    r = q;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        commit_d = 1'b0;
        ok_d     = ok_q;
        done_d   = 1'b0;
        q_d      = q_q;

        case (state_q)
            ST_IDLE: begin
                if (CFG_START) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // A restart wins over a simultaneous data bit.
                if (CFG_START) begin
                    cnt_d = '0;
                end else if (CFG_VALID) begin
                    shadow_d = {shadow_q[CFG_W-2:0], CFG_DIN};
                    if (cnt_q == CNT_W'(CFG_W - 1)) begin
                        state_d = ST_COMMIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                // Not abortable: CFG_START is ignored here.
                state_d  = ST_IDLE;
                commit_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // The copy lands one edge after COMMIT, so the new word drives X/Y two
        // edges after the last bit and CFG_DONE marks that same cycle. The
        // shadow cannot change in between: shifting restarts no earlier than
        // the copy edge itself.
        if (commit_q) begin
            active_d = shadow_q;
            ok_d     = 1'b1;
            done_d   = 1'b1;
        end

        // Q runs on the word active at this edge; a commit does not clear it.
        if (ok_q && ce) begin
            q_d = dsel ? g_val : f_val;
        end
    end

    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            commit_q <= 1'b0;
            ok_q     <= 1'b0;
            done_q   <= 1'b0;
            q_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so that every flop samples the
            // values from before this edge, regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            commit_q <= commit_d;
            ok_q     <= ok_d;
            done_q   <= done_d;
            q_q      <= q_d;
        end
    end

    assign CFG_READY = (state_q == ST_SHIFT);
    assign CFG_DONE  = done_q;
    assign CFG_OK    = ok_q;
    assign X         = ok_q ? out_sel(xsel, f_val, g_val, q_q) : 1'b0;
    assign Y         = ok_q ? out_sel(ysel, f_val, g_val, q_q) : 1'b0;

endmodule

// File: tb/tb_xc20xx_clb_cfg.sv
// -----------------------------------------------------------------------------
// tb_xc20xx_clb_cfg
//
// Directed bench for xc20xx_clb_cfg at LUT_K=3 (23-bit config word). Each
// scenario task drives its own stimulus and compares against hand-derived
// values. Inputs change 1 time unit after a rising edge; outputs are sampled
// there too.
// -----------------------------------------------------------------------------
module tb_xc20xx_clb_cfg;

    localparam int CFG_W = 23;

    logic       K;
    logic       RST_N;
    logic [3:0] in_v;
    logic       x_o;
    logic       y_o;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_din;
    logic       cfg_done;
    logic       cfg_ok;

    int tests_run    = 0;
    int tests_failed = 0;

    xc20xx_clb_cfg #(.LUT_K(3)) dut (
        .K         (K),
        .RST_N     (RST_N),
        .IN        (in_v),
        .X         (x_o),
        .Y         (y_o),
        .CFG_START (cfg_start),
        .CFG_VALID (cfg_valid),
        .CFG_READY (cfg_ready),
        .CFG_DIN   (cfg_din),
        .CFG_DONE  (cfg_done),
        .CFG_OK    (cfg_ok)
    );

    initial K = 1'b0;
    always #5 K = ~K;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [CFG_W-1:0] mk_word(
        input logic [7:0] f, input logic [7:0] g, input logic mux,
        input logic dsel, input logic cesel, input logic [1:0] xsel,
        input logic [1:0] ysel);
        return {f, g, mux, dsel, cesel, xsel, ysel};
    endfunction

    task automatic tick();
        @(posedge K);
        #1;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Sends nbits bits of w, starting at bit index (CFG_W-1-first), VALID held.
    task automatic shift_bits(input logic [CFG_W-1:0] w, input int first,
                              input int nbits);
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = w[CFG_W-1-first-i];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
    endtask

    // Edges from the last accepted bit until CFG_DONE is seen (-1 if never).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            tick();
            if (cfg_done === 1'b1) lat = c;
        end
    endtask

    // XOR3 / AND3 word, X=F, Y=G.
    logic [CFG_W-1:0] w2;
    // XOR3, Q from F with enable on IN[3], X=Q, Y=F.
    logic [CFG_W-1:0] w3;
    // OR3, enable on IN[3], X=F, Y=Q.
    logic [CFG_W-1:0] w4;
    // Aborted partial word and the word that replaces it (mux on).
    logic [CFG_W-1:0] wa;
    logic [CFG_W-1:0] w5;

    task automatic test_reset();
        logic [3:0] obs;
        RST_N = 1'b0;
        tick();
        tests_run++;
        obs = {x_o, y_o, cfg_ok, cfg_ready};
        if (obs !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_held: {X,Y,OK,READY}=%b expected 0000", obs);
        end
        tick();
        RST_N = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_v      = 4'($urandom);
            cfg_valid = c[0];
            cfg_din   = c[1];
            tick();
            tests_run++;
            obs = {x_o, y_o, cfg_ok, cfg_ready};
            if (obs !== 4'b0) begin
                tests_failed++;
                $display("FAIL reset_idle_c%0d: {X,Y,OK,READY}=%b expected 0000", c, obs);
            end
        end
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
    endtask

    task automatic test_first_load();
        in_v = 4'b0111;
        start_pulse();
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_ready: READY=%b expected 1", cfg_ready);
        end
        shift_bits(w2, 0, CFG_W);
        // Edge n: now in COMMIT.
        tests_run++;
        if ({cfg_ready, cfg_done, cfg_ok} !== 3'b000) begin
            tests_failed++;
            $display("FAIL load_commit: {READY,DONE,OK}=%b expected 000",
                     {cfg_ready, cfg_done, cfg_ok});
        end
        tick(); // edge n+1
        tests_run++;
        if ({cfg_done, x_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL load_n1: {DONE,X}=%b expected 00", {cfg_done, x_o});
        end
        tick(); // edge n+2
        tests_run++;
        if ({cfg_done, cfg_ok, x_o, y_o} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL load_n2: {DONE,OK,X,Y}=%b expected 1111",
                     {cfg_done, cfg_ok, x_o, y_o});
        end
        tick();
        tests_run++;
        if (cfg_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_done_pulse: DONE=%b expected 0", cfg_done);
        end
        in_v = 4'b0011;
        #1;
        tests_run++;
        if ({x_o, y_o, cfg_ok} !== 3'b001) begin
            tests_failed++;
            $display("FAIL load_func_0011: {X,Y,OK}=%b expected 001", {x_o, y_o, cfg_ok});
        end
    endtask

    task automatic test_flop_enable();
        int lat;
        start_pulse();
        shift_bits(w3, 0, CFG_W);
        wait_done(lat);
        tests_run++;
        if (lat != 2) begin
            tests_failed++;
            $display("FAIL ff_latency: got %0d expected 2", lat);
        end
        in_v = 4'b1001; // enabled, F(001)=1
        tick();
        tests_run++;
        if (x_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ff_load1: Q=%b expected 1", x_o);
        end
        in_v = 4'b0000; // disabled, F=0
        repeat (3) tick();
        tests_run++;
        if (x_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ff_hold1: Q=%b expected 1", x_o);
        end
        in_v = 4'b1000; // enabled, F(000)=0
        tick();
        tests_run++;
        if (x_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ff_load0: Q=%b expected 0", x_o);
        end
        in_v = 4'b0001; // disabled, F=1
        tick();
        tests_run++;
        if (x_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ff_hold0: Q=%b expected 0", x_o);
        end
        in_v = 4'b1001;
        tick();
        in_v = 4'b0000;
        tick();
        tests_run++;
        if (x_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ff_reload1: Q=%b expected 1", x_o);
        end
    endtask

    task automatic test_gapped_reconfig();
        int old_bad;
        int lat;
        old_bad = 0;
        in_v = 4'b0000; // old X = Q = 1, new X = OR3(000) = 0
        start_pulse();
        for (int i = 0; i < CFG_W; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = w4[CFG_W-1-i];
            tick();
            if (x_o !== 1'b1) old_bad++;
            if (i < CFG_W - 1) begin
                cfg_valid = 1'b0;
                cfg_din   = 1'b1;
                tick();
                if (x_o !== 1'b1) old_bad++;
            end
        end
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
        tests_run++;
        if (old_bad != 0) begin
            tests_failed++;
            $display("FAIL gap_old_func: %0d cycles with X!=1 during load, expected 0", old_bad);
        end
        wait_done(lat);
        tests_run++;
        if (lat != 2) begin
            tests_failed++;
            $display("FAIL gap_latency: got %0d expected 2", lat);
        end
        tests_run++;
        if ({x_o, y_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL gap_new_func: {X,Y}=%b expected 01 (X=OR3, Y=Q held)", {x_o, y_o});
        end
        in_v = 4'b0100;
        #1;
        tests_run++;
        if ({x_o, y_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL gap_or3: {X,Y}=%b expected 11", {x_o, y_o});
        end
    endtask

    task automatic test_restart();
        int saw_done;
        int lat;
        saw_done = 0;
        start_pulse();
        shift_bits(wa, 0, 10);
        // Restart with a valid bit in the same cycle: bit must be dropped.
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_din   = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < CFG_W - 1; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = w5[CFG_W-1-i];
            tick();
            if (cfg_done === 1'b1) saw_done++;
        end
        cfg_valid = 1'b0;
        tick();
        if (cfg_done === 1'b1) saw_done++;
        tests_run++;
        if (saw_done != 0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_22bits: done_pulses=%0d READY=%b expected 0 and 1",
                     saw_done, cfg_ready);
        end
        shift_bits(w5, CFG_W - 1, 1);
        wait_done(lat);
        tests_run++;
        if (lat != 2) begin
            tests_failed++;
            $display("FAIL restart_latency: got %0d expected 2", lat);
        end
        in_v = 4'b0101;
        #1;
        tests_run++;
        if ({x_o, y_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL restart_f_0101: {X,Y}=%b expected 10", {x_o, y_o});
        end
        in_v = 4'b1101;
        #1;
        tests_run++;
        if ({x_o, y_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL restart_mux_1101: {X,Y}=%b expected 00", {x_o, y_o});
        end
        in_v = 4'b1010;
        #1;
        tests_run++;
        if ({x_o, y_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL restart_mux_1010: {X,Y}=%b expected 11", {x_o, y_o});
        end
    endtask

    task automatic test_reset_midway();
        int saw_done;
        int lat;
        saw_done = 0;
        in_v = 4'b0111;
        start_pulse();
        shift_bits(w2, 0, 12);
        RST_N = 1'b0;
        #2;
        tests_run++;
        if ({x_o, y_o, cfg_done, cfg_ok, cfg_ready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rst_shift_async: {X,Y,DONE,OK,READY}=%b expected 00000",
                     {x_o, y_o, cfg_done, cfg_ok, cfg_ready});
        end
        #1;
        RST_N = 1'b1;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tests_run++;
        if ({cfg_ready, cfg_ok, x_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_shift_idle: {READY,OK,X}=%b expected 000",
                     {cfg_ready, cfg_ok, x_o});
        end
        start_pulse();
        shift_bits(w2, 0, CFG_W);
        // In COMMIT now.
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (cfg_done === 1'b1) saw_done++;
        end
        tests_run++;
        if (saw_done != 0 || {cfg_ok, x_o, y_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_commit: done_pulses=%0d {OK,X,Y}=%b expected 0 and 000",
                     saw_done, {cfg_ok, x_o, y_o});
        end
        start_pulse();
        shift_bits(w2, 0, CFG_W);
        wait_done(lat);
        tests_run++;
        if (lat != 2 || {cfg_ok, x_o, y_o} !== 3'b111) begin
            tests_failed++;
            $display("FAIL rst_reload: latency=%0d {OK,X,Y}=%b expected 2 and 111",
                     lat, {cfg_ok, x_o, y_o});
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        in_v      = 4'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
        w2 = mk_word(8'h96, 8'h80, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        w3 = mk_word(8'h96, 8'h80, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0);
        w4 = mk_word(8'hFE, 8'h80, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
        wa = mk_word(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3);
        w5 = mk_word(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);

        test_reset();
        test_first_load();
        test_flop_enable();
        test_gapped_reconfig();
        test_restart();
        test_reset_midway();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
